multiway_data_array: RTL

- Parametrised, multi-way cache data store, successor to the single-way 8-set byte-enabled data array.
- Generalised in way count, set count and line width; read port registered (1-cycle latency) with valid strobe.
- Write-first bypass on same-cycle same-location hits.
- Hardware init walker zeroes every line after reset. Sits under the L1/L2 cache controllers; the controller datapath muxes dataout by hit way.

---
 rtl/multiway_data_array.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multiway_data_array.sv
// multiway_data_array
// Multi-way cache data store: WAYS x SETS lines of LINE_BYTES bytes each.
// Byte-enabled writes, registered read port (1-cycle latency) with a valid
// strobe, write-first bypass on a same-cycle same-location read/write, and a
// hardware walker that zeroes every line after reset.
// Optional per-byte even parity is enabled with `define DATA_ARRAY_PARITY_EN
// (adds the par_inject input and a live rd_parity_err output).
module multiway_data_array #(
   parameter int WAYS       = 2,
   parameter int SETS       = 8,
   parameter int LINE_BYTES = 32,
   localparam int IDX_W     = $clog2(SETS),
   localparam int LW        = 8 * LINE_BYTES,
   localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_busy,
   input  logic                  rd_en,
   input  logic [WAY_W-1:0]      rd_way,
   input  logic [IDX_W-1:0]      rindex,
   output logic                  rd_valid,
   output logic [LW-1:0]         dataout,
   input  logic                  wr_en,
   input  logic [WAY_W-1:0]      wr_way,
   input  logic [IDX_W-1:0]      windex,
   input  logic [LINE_BYTES-1:0] write_en,
   input  logic [LW-1:0]         datain,
`ifdef DATA_ARRAY_PARITY_EN
   input  logic [LINE_BYTES-1:0] par_inject,
`endif
   output logic [LINE_BYTES-1:0] rd_parity_err
);

   // Storage is addressed by {way, set}; with a non power-of-two way count
   // the upper entries are simply never written or read.
   localparam int AW        = WAY_W + IDX_W;
   localparam int MEM_DEPTH = 1 << AW;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        count_q, count_d;
   logic                    init_busy_q, init_busy_d;
   logic                    rd_valid_q;
   logic [LW-1:0]           dataout_q;
   logic [LW-1:0]           mem_q [MEM_DEPTH];

   logic                    rd_acc_s;
   logic                    wr_acc_s;
   logic                    bypass_s;
   logic [LW-1:0]           rd_line_s;

`ifdef DATA_ARRAY_PARITY_EN
   logic [LINE_BYTES-1:0]   par_q [MEM_DEPTH];
   logic [LINE_BYTES-1:0]   rd_err_s;
   logic [LINE_BYTES-1:0]   rd_err_q;
`endif

   // Even parity bit for one byte: makes the 9-bit total have an even count of ones.
   function automatic logic even_par(input logic [7:0] byte_i);
      return ^byte_i;
   endfunction

   // True when the way number addresses a populated way.
   function automatic logic way_in_range(input logic [WAY_W-1:0] way_i);
      return ({1'b0, way_i} < (WAY_W + 1)'(WAYS));
   endfunction

   assign rd_acc_s = rd_en & (state_q == ST_READY);
   assign wr_acc_s = wr_en & (state_q == ST_READY) & way_in_range(wr_way);
   assign bypass_s = rd_acc_s & wr_acc_s & (rd_way == wr_way) & (rindex == windex);

   // Next-state logic for the init walker: one set per cycle, then READY until reset.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      init_busy_d = 1'b0;
      case (state_q)
         ST_INIT: begin
            count_d     = count_q + {{(IDX_W-1){1'b0}}, 1'b1};
            init_busy_d = 1'b1;
            if (count_q == IDX_W'(SETS - 1)) begin
               state_d     = ST_READY;
               init_busy_d = 1'b0;
            end else begin
               state_d     = ST_INIT;
            end
         end
         ST_READY: begin
            state_d     = ST_READY;
            count_d     = count_q;
            init_busy_d = 1'b0;
         end
         default: begin
            state_d     = ST_INIT;
            count_d     = '0;
            init_busy_d = 1'b1;
         end
      endcase
   end

   // Walker state register; any reset restarts the walk from set 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         count_q     <= '0;
         init_busy_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         init_busy_q <= init_busy_d;
      end
   end

   // Line storage: walker zeroing during init, byte-enabled writes afterwards.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         for (int w = 0; w < WAYS; w++) begin
            mem_q[{WAY_W'(w), count_q}] <= '0;
`ifdef DATA_ARRAY_PARITY_EN
            par_q[{WAY_W'(w), count_q}] <= '0;
`endif
         end
      end else if (wr_acc_s) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (write_en[b]) begin
               mem_q[{wr_way, windex}][8*b +: 8] <= datain[8*b +: 8];
`ifdef DATA_ARRAY_PARITY_EN
               par_q[{wr_way, windex}][b] <= even_par(datain[8*b +: 8]) ^ par_inject[b];
`endif
            end
         end
      end
   end

   // Read-side line selection with write-first byte bypass.
   always_comb begin
      rd_line_s = '0;
`ifdef DATA_ARRAY_PARITY_EN
      rd_err_s  = '0;
`endif
      if (way_in_range(rd_way)) begin
         rd_line_s = mem_q[{rd_way, rindex}];
`ifdef DATA_ARRAY_PARITY_EN
         for (int b = 0; b < LINE_BYTES; b++) begin
            rd_err_s[b] = even_par(rd_line_s[8*b +: 8]) ^ par_q[{rd_way, rindex}][b];
         end
`endif
      end else begin
         rd_line_s = '0;
      end
      if (bypass_s) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (write_en[b]) begin
               rd_line_s[8*b +: 8] = datain[8*b +: 8];
`ifdef DATA_ARRAY_PARITY_EN
               rd_err_s[b] = 1'b0;
`endif
            end else begin
               rd_line_s[8*b +: 8] = rd_line_s[8*b +: 8];
            end
         end
      end else begin
         rd_line_s = rd_line_s;
      end
   end

   // Registered read port: data holds when idle, valid pulses per accepted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         dataout_q  <= '0;
`ifdef DATA_ARRAY_PARITY_EN
         rd_err_q   <= '0;
`endif
      end else if (rd_acc_s) begin
         rd_valid_q <= 1'b1;
         dataout_q  <= rd_line_s;
`ifdef DATA_ARRAY_PARITY_EN
         rd_err_q   <= rd_err_s;
`endif
      end else begin
         rd_valid_q <= 1'b0;
         dataout_q  <= dataout_q;
`ifdef DATA_ARRAY_PARITY_EN
         rd_err_q   <= '0;
`endif
      end
   end

   assign init_busy = init_busy_q;
   assign rd_valid  = rd_valid_q;
   assign dataout   = dataout_q;
`ifdef DATA_ARRAY_PARITY_EN
   assign rd_parity_err = rd_err_q;
`else
   assign rd_parity_err = '0;
`endif

endmodule
